// File: rtl/mul_div_seq_divider.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per cycle,
// quotient to lo, remainder to hi, start/busy/done handshake.
module mul_div_seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] lo,
  output logic [31:0] hi,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] rem_r;
  logic [31:0] q_r;
  logic [31:0] dvs_r;
  logic [4:0]  cnt_r;
  logic        q_neg_r;
  logic        r_neg_r;

  logic [32:0] rem_sh_s;
  logic [31:0] diff_s;
  logic        carry_s;
  logic        no_borrow_s;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (32'd0 - v) : v;
  endfunction

  // Trial subtraction: the bit shifted out of rem forces "fits", otherwise
  // the carry of rem + ~divisor + 1 decides.
  always_comb begin
    rem_sh_s             = {rem_r, q_r[31]};
    {carry_s, diff_s}    = {1'b0, rem_sh_s[31:0]} + {1'b0, ~dvs_r} + 33'd1;
    no_borrow_s          = rem_sh_s[32] | carry_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == 5'd0) state_s = FINISH;
        else               state_s = RUN;
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rem_r       <= 32'd0;
      q_r         <= 32'd0;
      dvs_r       <= 32'd0;
      cnt_r       <= 5'd0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lo          <= 32'd0;
      hi          <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      done    <= (state_r == FINISH);
      case (state_r)
        IDLE: begin
          if (start) begin
            rem_r   <= 32'd0;
            q_r     <= neg_if(dividend, is_signed & dividend[31]);
            dvs_r   <= neg_if(divisor, is_signed & divisor[31]);
            cnt_r   <= 5'd31;
            q_neg_r <= is_signed & (dividend[31] ^ divisor[31]);
            r_neg_r <= is_signed & dividend[31];
          end
        end
        RUN: begin
          q_r   <= {q_r[30:0], no_borrow_s};
          rem_r <= no_borrow_s ? diff_s : rem_sh_s[31:0];
          cnt_r <= cnt_r - 5'd1;
        end
        FINISH: begin
          lo          <= neg_if(q_r, q_neg_r);
          hi          <= neg_if(rem_r, r_neg_r);
          div_by_zero <= (dvs_r == 32'd0);
        end
        default: begin
          rem_r <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq_divider.sv
// Self-checking bench for mul_div_seq_divider: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_mul_div_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  mul_div_seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .lo(lo), .hi(hi), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: divide magnitudes with plain arithmetic, then apply signs.
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    z  = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
  endtask

  // Issues one division (optionally poking start at cycle poke) and checks
  // latency, busy duration, results. Returns #1 after the done edge.
  task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int poke);
    logic [31:0] eq, er;
    logic ez;
    int lat, busy_cnt;
    ref_div(s, a, b, eq, er, ez);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == poke) begin
        is_signed = 1'b0; dividend = 32'd5; divisor = 32'd5; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
    chk({tag, " latency"}, lat, 32'd33);
    chk({tag, " busy_cycles"}, busy_cnt, 32'd33);
    chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " lo"}, lo, eq);
    chk({tag, " hi"}, hi, er);
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  initial begin
    logic [31:0] ra, rb, lo_hold;
    logic rs;
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
    chk("divu_100_7 lo_abs", lo, 32'd14);
    lo_hold = lo;
    @(posedge clk); #1;
    chk("done_single_cycle", {31'd0, done}, 32'd0);
    chk("lo_holds", lo, lo_hold);
    do_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 0);
    chk("div_m100_7 lo_abs", lo, 32'hFFFF_FFF2);
    chk("div_m100_7 hi_abs", hi, 32'hFFFF_FFFE);
    do_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 0);
    do_div("divu_by_zero", 1'b0, 32'h1234_5678, 32'd0, 0);
    chk("divu_by_zero lo_abs", lo, 32'hFFFF_FFFF);
    chk("dbz_held", {31'd0, div_by_zero}, 32'd1);
    do_div("divu_10_3", 1'b0, 32'd10, 32'd3, 0);
    chk("divu_10_3 dbz_clear", {31'd0, div_by_zero}, 32'd0);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_min_m1 lo_abs", lo, 32'h8000_0000);
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_div("div_m5_by_zero", 1'b1, 32'hFFFF_FFFB, 32'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    do_div("ignore_start", 1'b0, 32'd1000, 32'd10, 10);
    chk("ignore_start lo_abs", lo, 32'd100);
    do_div("back_to_back", 1'b0, 32'd9, 32'd2, 0);
    chk("back_to_back lo_abs", lo, 32'd4);

    // Asynchronous reset in the middle of an operation.
    is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrun_rst busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst done", {31'd0, done}, 32'd0);
    chk("midrun_rst lo", lo, 32'd0);
    chk("midrun_rst hi", hi, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_div("after_rst_7_7", 1'b0, 32'd7, 32'd7, 0);

    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 20));
        3:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if (i % 3 == 0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
      end
      do_div("random", rs, ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
